fetch_unit: RTL

// - Initiator (read master) for mainmem: drives a word-aligned fetch address, samples mainmem's

---
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: flow-controlled, redirectable instruction fetch front end.
//
// Acts as a read master for mainmem. It presents a registered word-aligned
// address, samples mainmem's combinational data_out in the same cycle, and
// queues {pc, instruction} pairs for the decode stage.
//
// Ports:
//   clock, reset          single clock; asynchronous active-high reset
//   run                   1 = new fetches allowed; 0 = hold PC (queue still drains)
//   mem_address           fetch address to mainmem (equals the PC register)
//   mem_data_in           to mainmem data_in, always 0
//   mem_read_write        to mainmem read_write, always READ (0)
//   mem_data_out          instruction word from mainmem for mem_address
//   insn_valid/insn/insn_pc   queue head presented to decode
//   insn_ready            decode accepts the head this cycle
//   redirect_valid/redirect_pc  branch/jump redirect; flushes the queue
//   fetch_error           sticky misaligned-redirect flag
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets (sticky fetch_error, fetch halts until reset). Without it the low
// two target bits are ignored and fetch_error is tied to 0.

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0100_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_read_write,
   input  logic [31:0] mem_data_out,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn,
   output logic [31:0] insn_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_error
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   // Shift-register queue: entry 0 is always the head, so the head outputs
   // come straight from flops and keep their last value when the queue empties.
   logic [31:0]   ent_pc_q   [FIFO_DEPTH];
   logic [31:0]   ent_pc_d   [FIFO_DEPTH];
   logic [31:0]   ent_insn_q [FIFO_DEPTH];
   logic [31:0]   ent_insn_d [FIFO_DEPTH];

   logic          pop;
   logic          fetch_fire;
   logic [CW-1:0] push_idx;

`ifdef FETCH_ALIGN_CHECK_EN
   logic err_q, err_d;
`else
   logic unused_align_bits;
   assign unused_align_bits = ^redirect_pc[1:0];
`endif

   assign mem_address    = pc_q;
   assign mem_data_in    = '0;
   assign mem_read_write = 1'b0;
   assign insn_valid     = (count_q != '0);
   assign insn           = ent_insn_q[0];
   assign insn_pc        = ent_pc_q[0];
`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_error    = err_q;
`else
   assign fetch_error    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      count_d    = count_q;
      ent_pc_d   = ent_pc_q;
      ent_insn_d = ent_insn_q;
`ifdef FETCH_ALIGN_CHECK_EN
      err_d      = err_q;
`endif

      pop        = insn_valid & insn_ready;
      fetch_fire = (state_q == S_RUN) & run & ~redirect_valid
                   & ((count_q < DEPTH_C) | pop);
      // Tail slot after any pop this cycle; push requires room so it is in range.
      push_idx   = count_q - CW'(pop);

      case (state_q)
         S_IDLE:  state_d = S_RUN;
         default: state_d = state_q;
      endcase

      if (redirect_valid) begin
         // Redirect wins: flush (any same-cycle pop is dropped) and retarget.
         count_d = '0;
         pc_d    = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_HALT;
         end
`endif
      end else begin
         // Only shift when an entry remains behind the head, so a pop of the
         // last entry leaves the head registers holding their previous value.
         if (pop && (count_q > CW'(1))) begin
            for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
               ent_pc_d[i]   = ent_pc_q[i + 1];
               ent_insn_d[i] = ent_insn_q[i + 1];
            end
         end
         if (fetch_fire) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
               if (CW'(i) == push_idx) begin
                  ent_pc_d[i]   = pc_q;
                  ent_insn_d[i] = mem_data_out;
               end
            end
            pc_d = pc_q + 32'd4;
         end
         count_d = count_q - CW'(pop) + CW'(fetch_fire);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         count_q <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            ent_pc_q[i]   <= '0;
            ent_insn_q[i] <= '0;
         end
`ifdef FETCH_ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            ent_pc_q[i]   <= ent_pc_d[i];
            ent_insn_q[i] <= ent_insn_d[i];
         end
`ifdef FETCH_ALIGN_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule
